six_tap_window_feeder: RTL and testbench

Upstream feeder for the six-tap half-pel filter stage in the FME datapath. It accepts a raw row of integer-pel luma pixels as a valid/ready stream. It maintains a six-deep sliding window with edge replication at both row ends. For every pixel position k in the row it emits one registered tap set (a..f), which connects directly to the filter's a..f inputs.

---
 rtl/fme_pkg.sv | 14 +
 rtl/tap_shift6.sv | 44 ++++
 rtl/six_tap_window_feeder.sv | 151 +++++++++++++++
 tb/tb_six_tap_window_feeder.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fme_pkg.sv
// Shared FME datapath types and widths.
// Used by the six-tap window feeder and the half-pel filter.
package fme_pkg;

  localparam int PIX_W  = 8;
  localparam int TAP_N  = 6;
  localparam int HALF_W = 13;

  typedef enum logic {
    RUN,
    DRAIN
  } feed_state_t;

endpackage

// File: rtl/tap_shift6.sv
// Six-entry pixel register bank for the tap window.
// Exposes its next-state so a window can be captured on the same edge.
module tap_shift6 #(
  parameter int W = fme_pkg::PIX_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_load_all,
  input  logic                          i_shift,
  input  logic                          i_rep,
  input  logic [W-1:0]                  i_pix,
  output logic [fme_pkg::TAP_N*W-1:0]   o_nxt
);
  import fme_pkg::*;

  logic [W-1:0] r_s [TAP_N];
  logic [W-1:0] w_n [TAP_N];

  // next contents: replicate-load, shift in a pixel, or re-shift the newest
  always_comb begin
    for (int i = 0; i < TAP_N; i++) w_n[i] = r_s[i];
    if (i_load_all) begin
      for (int i = 0; i < TAP_N; i++) w_n[i] = i_pix;
    end else if (i_shift || i_rep) begin
      for (int i = 0; i < TAP_N - 1; i++) w_n[i] = r_s[i+1];
      w_n[TAP_N-1] = i_shift ? i_pix : r_s[TAP_N-1];
    end
  end

  // bank register
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAP_N; i++) r_s[i] <= '0;
    end else begin
      for (int i = 0; i < TAP_N; i++) r_s[i] <= w_n[i];
    end
  end

  // flatten, entry 0 (oldest) in the low bits
  always_comb begin
    for (int i = 0; i < TAP_N; i++) o_nxt[i*W +: W] = w_n[i];
  end

endmodule

// File: rtl/six_tap_window_feeder.sv
// Sliding six-tap window feeder with edge replication for the half-pel filter.
// Optional start-of-row resync input enabled by SIX_TAP_FEED_SOR_EN.
module six_tap_window_feeder #(
  parameter int PIX_W   = fme_pkg::PIX_W,
  parameter int ROW_LEN = 16,
  parameter int COL_W   = $clog2(ROW_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
`ifdef SIX_TAP_FEED_SOR_EN
  input  logic             in_sor,
  output logic             err_sync,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_a,
  output logic [PIX_W-1:0] out_b,
  output logic [PIX_W-1:0] out_c,
  output logic [PIX_W-1:0] out_d,
  output logic [PIX_W-1:0] out_e,
  output logic [PIX_W-1:0] out_f,
  output logic [COL_W-1:0] out_col,
  output logic             out_last
);
  import fme_pkg::*;

  feed_state_t r_state;
  feed_state_t w_state_nxt;

  logic [COL_W-1:0]         r_col;
  logic [1:0]               r_dcnt;
  logic                     r_valid;
  logic [PIX_W-1:0]         r_tap [TAP_N];
  logic [COL_W-1:0]         r_ocol;
  logic                     r_last;

  logic                     w_slot_free;
  logic                     w_acc;
  logic                     w_dstep;
  logic                     w_sor;
  logic                     w_first;
  logic                     w_col_last;
  logic                     w_load;
  logic [COL_W-1:0]         w_wcol;
  logic [TAP_N*PIX_W-1:0]   w_nxt;

`ifdef SIX_TAP_FEED_SOR_EN
  logic r_err;
  assign w_sor    = in_sor;
  assign err_sync = r_err;
`else
  assign w_sor = 1'b0;
`endif

  assign w_slot_free = !r_valid || out_ready;
  assign w_acc       = in_valid && in_ready;
  assign w_first     = (r_col == '0) || w_sor;
  assign w_col_last  = (r_col == COL_W'(ROW_LEN - 1));
  assign w_load      = (w_acc && !w_first && (r_col >= COL_W'(3)))
                     || w_dstep;
  assign w_wcol      = w_dstep
                     ? COL_W'(ROW_LEN - 3) + COL_W'(r_dcnt)
                     : r_col - COL_W'(3);

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // next state, input handshake and drain stepping
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_dstep     = 1'b0;
    unique case (r_state)
      RUN: begin
        in_ready = w_slot_free;
        if (w_acc && w_col_last && !w_sor) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_dstep = w_slot_free;
        if (w_dstep && (r_dcnt == 2'd2)) w_state_nxt = RUN;
      end
    endcase
  end

  tap_shift6 #(.W(PIX_W)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .i_load_all (w_acc && w_first),
    .i_shift    (w_acc && !w_first),
    .i_rep      (w_dstep),
    .i_pix      (in_pix),
    .o_nxt      (w_nxt)
  );

  // column and drain counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_dcnt <= '0;
    end else begin
      if (w_acc) begin
        if (w_first)         r_col <= COL_W'(1);
        else if (w_col_last) r_col <= '0;
        else                 r_col <= r_col + COL_W'(1);
      end
      if (w_dstep) r_dcnt <= (r_dcnt == 2'd2) ? 2'd0 : r_dcnt + 2'd1;
    end
  end

  // output window register, held under backpressure
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ocol  <= '0;
      r_last  <= 1'b0;
      for (int i = 0; i < TAP_N; i++) r_tap[i] <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_ocol  <= w_wcol;
      r_last  <= w_dstep && (r_dcnt == 2'd2);
      for (int i = 0; i < TAP_N; i++) r_tap[i] <= w_nxt[i*PIX_W +: PIX_W];
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef SIX_TAP_FEED_SOR_EN
  // sticky flag for a start-of-row seen mid-row
  always_ff @(posedge clk) begin
    if (rst)                               r_err <= 1'b0;
    else if (w_acc && w_sor && r_col != '0) r_err <= 1'b1;
  end
`endif

  assign out_valid = r_valid;
  assign out_a     = r_tap[0];
  assign out_b     = r_tap[1];
  assign out_c     = r_tap[2];
  assign out_d     = r_tap[3];
  assign out_e     = r_tap[4];
  assign out_f     = r_tap[5];
  assign out_col   = r_ocol;
  assign out_last  = r_last;

endmodule

// File: tb/tb_six_tap_window_feeder.sv
// Randomized scoreboard bench for six_tap_window_feeder (ROW_LEN=8).
// Reference windows are built from the accepted row by clamped indexing.
module tb_six_tap_window_feeder;
  localparam int W  = 8;
  localparam int RL = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_pix;
  logic          in_sor;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_a, out_b, out_c, out_d, out_e, out_f;
  logic [CW-1:0] out_col;
  logic          out_last;
  logic          sor_eff;
`ifdef SIX_TAP_FEED_SOR_EN
  logic          err_sync;
  assign sor_eff = in_sor;
`else
  assign sor_eff = 1'b0;
`endif

  six_tap_window_feeder #(.PIX_W(W), .ROW_LEN(RL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
`ifdef SIX_TAP_FEED_SOR_EN
    .in_sor    (in_sor),
    .err_sync  (err_sync),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  logic [63:0] obs;
  assign obs = {12'h0, out_a, out_b, out_c, out_d, out_e, out_f,
                out_col, out_last};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  int          prow [RL];
  int          mj = 0;
  logic [63:0] expq [$];
  logic [63:0] logq [$];
  bit          exp_err = 0;
  bit          rand_rdy = 0;

  function automatic int clampi(int i);
    if (i < 0) return 0;
    if (i > RL - 1) return RL - 1;
    return i;
  endfunction

  function automatic logic [63:0] win(int k);
    logic [63:0] v = 0;
    for (int i = 0; i < 6; i++) v = (v << 8) | 64'(prow[clampi(k - 2 + i)]);
    v = (v << 4) | 64'(k << 1) | 64'(k == RL - 1);
    return v;
  endfunction

  task automatic model_acc(input int pix, input bit sor);
    if (sor) begin
      if (mj != 0) exp_err = 1;
      mj = 0;
    end
    prow[mj] = pix;
    if (mj >= 3) expq.push_back(win(mj - 3));
    if (mj == RL - 1) begin
      for (int k = RL - 3; k < RL; k++) expq.push_back(win(k));
      mj = 0;
    end else begin
      mj++;
    end
  endtask

  // scoreboard: sample handshakes just before the edge that commits them
  always @(negedge clk) begin
    if (rst) begin
      mj = 0;
      exp_err = 0;
      expq.delete();
    end else begin
      if (in_valid && in_ready) model_acc(int'(in_pix), sor_eff);
      if (out_valid && out_ready) begin
        logq.push_back(obs);
        if (expq.size() == 0) chk("spurious", 64'(expq.size()), 64'd1);
        else chk("win", obs, expq.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic put(input int p, input bit sor);
    bit ok = 0;
    in_valid = 1'b1;
    in_pix   = W'(p);
    in_sor   = sor;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("put_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sor   = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (expq.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 64'(ok), 64'd1);
  endtask

  logic [63:0] hold;
  logic [63:0] wv;
  int          lo;
  int          a, b, c, d, e, f;
  bit          seen;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pix = '0; in_sor = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_win", obs, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    logq.delete();
    for (int i = 0; i < RL; i++) put((i + 1) * 10, 0);
    lo = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready) break;
      lo++;
    end
    chk("drain_gap", 64'(lo), 64'd3);
    wait_idle();
    chk("row_cnt", 64'(logq.size()), 64'd8);
    chk("k0", logq[0], {12'h0, 8'd10, 8'd10, 8'd10, 8'd20, 8'd30, 8'd40,
                        3'd0, 1'b0});
    chk("k3", logq[3], {12'h0, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70,
                        3'd3, 1'b0});
    chk("k7", logq[7], {12'h0, 8'd60, 8'd70, 8'd80, 8'd80, 8'd80, 8'd80,
                        3'd7, 1'b1});

    logq.delete();
    for (int i = 0; i < RL; i++) put(100, 0);
    wait_idle();
    chk("flat_cnt", 64'(logq.size()), 64'd8);
    foreach (logq[i]) begin
      wv = logq[i];
      a = int'(wv[51:44]); b = int'(wv[43:36]); c = int'(wv[35:28]);
      d = int'(wv[27:20]); e = int'(wv[19:12]); f = int'(wv[11:4]);
      chk("flat_half", 64'(a - 5*b + 20*c + 20*d - 5*e + f), 64'd3200);
    end

    fork
      begin
        for (int i = 0; i < RL; i++) put(int'($urandom_range(0, 255)), 0);
      end
      begin
        seen = 0;
        for (int t = 0; t < 200; t++) begin
          @(posedge clk);
          #1;
          if (out_valid && out_col == 3'd2) begin
            seen = 1;
            break;
          end
        end
        chk("stall_seen", 64'(seen), 64'd1);
        out_ready = 1'b0;
        hold = obs;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          chk("stall_hold", obs, hold);
          chk("stall_rdy", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_idle();

    logq.delete();
    for (int i = 0; i < 2 * RL; i++) put(int'($urandom_range(0, 255)), 0);
    wait_idle();
    chk("b2b_cnt", 64'(logq.size()), 64'd16);
    foreach (logq[i]) begin
      wv = logq[i];
      chk("b2b_col", 64'(wv[3:1]), 64'(i % RL));
    end

    for (int i = 0; i < 5; i++) put(int'($urandom_range(0, 255)), 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid", 64'(out_valid), 64'd0);
    logq.delete();
    for (int i = 0; i < RL; i++) put(int'($urandom_range(0, 255)), 0);
    wait_idle();
    chk("rst_row_cnt", 64'(logq.size()), 64'd8);

    rand_rdy = 1;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < RL; i++) begin
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
        put(int'($urandom_range(0, 255)), 0);
      end
    end
    wait_idle();
    rand_rdy = 0;
    @(posedge clk);
    #1 out_ready = 1'b1;

`ifdef SIX_TAP_FEED_SOR_EN
    chk("err_pre", 64'(err_sync), 64'd0);
    logq.delete();
    for (int i = 0; i < 3; i++) put(i + 1, 0);
    put(200, 1);
    for (int i = 0; i < RL - 1; i++) put(210 + i, 0);
    wait_idle();
    chk("err_set", 64'(err_sync), 64'(exp_err));
    chk("sor_k0", logq[0], {12'h0, 8'd200, 8'd200, 8'd200, 8'd210, 8'd211,
                            8'd212, 3'd0, 1'b0});
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("err_sticky", 64'(err_sync), 64'd1);
`endif

    chk("leftover", 64'(expq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
